// File: rtl/note_synth_pkg.sv
// Shared types and constants for the note synthesiser and its serial divider.
package note_synth_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_STORE} div_state_e;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;
  localparam logic [2:0] VOL_MIN  = 3'd1;
  localparam int         DVD_W    = 32;

  function automatic int amp_shift(input int sample_w);
    return sample_w - 4;
  endfunction
endpackage

// File: rtl/note_synth_if.sv
// Control pulses, note frequencies and sample/status outputs of note_synth.
interface note_synth_if #(parameter int NUM_CH = 2, parameter int SAMPLE_W = 16);
  logic                         vol_up, vol_down, oct_up, oct_down, mute;
  logic [NUM_CH*16-1:0]         freq_in;
  logic [NUM_CH*SAMPLE_W-1:0]   audio_out;
  logic [2:0]                   vol;
  logic [1:0]                   oct;
  logic                         div_ready;

  modport master (output vol_up, vol_down, oct_up, oct_down, mute, freq_in,
                  input  audio_out, vol, oct, div_ready);
  modport slave  (input  vol_up, vol_down, oct_up, oct_down, mute, freq_in,
                  output audio_out, vol, oct, div_ready);
endinterface

// File: rtl/serial_udiv.sv
// 32-bit restoring unsigned divider: one quotient bit per cycle, done pulses after 32 cycles.
module serial_udiv import note_synth_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVD_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dzero_o,
  output logic [DVD_W-1:0] quot_o
);
  logic [DVD_W-1:0] quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [DVD_W:0]   rem_sh;
  logic [4:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  always_comb begin
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    rem_sh = {rem_q, quo_q[DVD_W-1]};
    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
      dz_d   = (divisor_i == '0);
    end else if (busy_q) begin
      // dividend bits leave at the MSB while quotient bits enter at the LSB
      quo_d = {quo_q[DVD_W-2:0], 1'b0};
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d    = DVD_W'(rem_sh - {1'b0, dvs_q});
        quo_d[0] = 1'b1;
      end else begin
        rem_d = rem_sh[DVD_W-1:0];
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0; dvs_q <= '0; rem_q <= '0; cnt_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; dz_q <= 1'b0;
    end else begin
      quo_q <= quo_d; dvs_q <= dvs_d; rem_q <= rem_d; cnt_q <= cnt_d;
      busy_q <= busy_d; done_q <= done_d; dz_q <= dz_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign dzero_o = dz_q;
  assign quot_o  = quo_q;
endmodule

// File: rtl/note_synth.sv
// Multi-channel square-wave synthesiser: round-robin serial divider turns Hz into
// half-period dividers; per-channel tone counters drive registered signed samples.
module note_synth import note_synth_pkg::*; #(
  parameter int NUM_CH   = 2,
  parameter int CLK_HZ   = 100000000,
  parameter int DIV_W    = 22,
  parameter int SAMPLE_W = 16,
  parameter int VOL_MAX  = 5
) (
  input logic clk,
  input logic rst,
  note_synth_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DVD_W-1:0] HALF_CLK = DVD_W'(CLK_HZ / 2);
  localparam logic [DVD_W-1:0] DIV_MAX  = DVD_W'((64'd1 << DIV_W) - 64'd1);

  logic [2:0] vol_q, vol_d;
  logic [1:0] oct_q, oct_d;
  div_state_e state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [NUM_CH-1:0] silent_q, silent_d, ph_q, ph_d;
  logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] audio_q, audio_d;
  logic [NUM_CH-1:0][15:0] freq;
  logic rdy_q, rdy_d, zero_q, zero_d;
  logic [15:0] fsel;
  logic [16:0] feff;
  logic start, busy, done, dzero;
  logic [DVD_W-1:0] quot;
  logic [SAMPLE_W-1:0] amp;

  assign freq = bus.freq_in;
  assign fsel = freq[ch_q];

  always_comb begin
    case (oct_q)
      OCT_LOW:  feff = {2'b0, fsel[15:1]};
      OCT_HIGH: feff = {fsel, 1'b0};
      default:  feff = {1'b0, fsel};
    endcase
  end

  always_comb begin
    vol_d = vol_q;
    oct_d = oct_q;
    if (bus.vol_up && !bus.vol_down && vol_q < 3'(VOL_MAX)) vol_d = vol_q + 3'd1;
    else if (bus.vol_down && !bus.vol_up && vol_q > VOL_MIN) vol_d = vol_q - 3'd1;
    if (bus.oct_up && !bus.oct_down && oct_q < OCT_HIGH) oct_d = oct_q + 2'd1;
    else if (bus.oct_down && !bus.oct_up && oct_q > OCT_LOW) oct_d = oct_q - 2'd1;
  end

  serial_udiv u_div (
    .clk(clk), .rst(rst), .start_i(start), .dividend_i(HALF_CLK),
    .divisor_i({{(DVD_W-17){1'b0}}, feff}),
    .busy_o(busy), .done_o(done), .dzero_o(dzero), .quot_o(quot)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    silent_d = silent_q;
    div_d    = div_q;
    rdy_d    = rdy_q;
    zero_d   = zero_q;
    start    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        if (feff == 17'd0) begin
          zero_d         = 1'b1;
          silent_d[ch_q] = 1'b1;
          state_d        = S_STORE;
        end else begin
          zero_d  = 1'b0;
          start   = 1'b1;
          state_d = S_ITER;
        end
      end
      S_ITER: if (done && !busy) state_d = S_STORE;
      S_STORE: begin
        // a rest keeps the old divider; the channel is simply held silent
        if (!zero_q && !dzero) begin
          div_d[ch_q]    = (quot > DIV_MAX) ? DIV_MAX[DIV_W-1:0] : quot[DIV_W-1:0];
          silent_d[ch_q] = 1'b0;
        end
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d  = '0;
          rdy_d = 1'b1;
        end else begin
          ch_d = ch_q + 1'b1;
        end
        state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign amp = SAMPLE_W'({1'b0, vol_q} + 4'd1) << amp_shift(SAMPLE_W);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c] + 1'b1;
      ph_d[c]  = ph_q[c];
      if (silent_q[c]) begin
        cnt_d[c] = '0;
        ph_d[c]  = 1'b0;
      end else if (cnt_q[c] >= div_q[c]) begin
        cnt_d[c] = '0;
        ph_d[c]  = ~ph_q[c];
      end
      audio_d[c] = (bus.mute || silent_q[c]) ? '0 : (ph_q[c] ? amp : -amp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vol_q    <= VOL_MIN;
      oct_q    <= OCT_MID;
      state_q  <= S_IDLE;
      ch_q     <= '0;
      silent_q <= '1;
      ph_q     <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      audio_q  <= '0;
      rdy_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      vol_q    <= vol_d;
      oct_q    <= oct_d;
      state_q  <= state_d;
      ch_q     <= ch_d;
      silent_q <= silent_d;
      ph_q     <= ph_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      audio_q  <= audio_d;
      rdy_q    <= rdy_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.vol       = vol_q;
  assign bus.oct       = oct_q;
  assign bus.div_ready = rdy_q;
endmodule

// File: tb/tb_note_synth.sv
// Bench for note_synth: clamp model for vol/oct, Hz-to-divider model, toggle-spacing checks.
module tb_note_synth;
  import note_synth_pkg::*;
  localparam int NUM_CH = 2, SAMPLE_W = 16, DIV_W = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vecs = 0, errs = 0;
  int   m_vol = 1, m_oct = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  note_synth_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus();
  note_synth #(.NUM_CH(NUM_CH), .CLK_HZ(100000000), .DIV_W(DIV_W),
               .SAMPLE_W(SAMPLE_W), .VOL_MAX(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic int exp_div(input int f, input int o);
    int fe, q;
    fe = (o == 0) ? (f >> 1) : (o == 2) ? (f << 1) : f;
    if (fe == 0) return 0;
    q = 50000000 / fe;
    if (q > 4194303) q = 4194303;
    return q;
  endfunction

  function automatic logic [SAMPLE_W-1:0] smp(input int ch);
    return bus.audio_out[ch*SAMPLE_W +: SAMPLE_W];
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit vu, input bit vd, input bit ou, input bit od);
    bus.vol_up = vu; bus.vol_down = vd; bus.oct_up = ou; bus.oct_down = od;
    if (vu && !vd && m_vol < 5) m_vol++;
    else if (vd && !vu && m_vol > 1) m_vol--;
    if (ou && !od && m_oct < 2) m_oct++;
    else if (od && !ou && m_oct > 0) m_oct--;
    step(1);
    bus.vol_up = 0; bus.vol_down = 0; bus.oct_up = 0; bus.oct_down = 0;
  endtask

  task automatic set_oct(input int target);
    while (m_oct < target) pulse(0, 0, 1, 0);
    while (m_oct > target) pulse(0, 0, 0, 1);
  endtask

  // Finds two consecutive sign changes of a channel's sample (ignoring zeros).
  task automatic measure(input int ch, input int budget, output int t_first,
                         output int sp, output bit ok);
    logic [SAMPLE_W-1:0] s;
    bit prev, prev_nz;
    int edges;
    ok = 0; sp = 0; t_first = 0; edges = 0; prev = 0; prev_nz = 0;
    for (int n = 0; n < budget && edges < 2; n++) begin
      step(1);
      s = smp(ch);
      if (s != '0) begin
        if (prev_nz && s[SAMPLE_W-1] != prev) begin
          edges++;
          if (edges == 1) t_first = cyc;
          else begin sp = cyc - t_first; ok = 1; end
        end
        prev = s[SAMPLE_W-1];
        prev_nz = 1;
      end
    end
  endtask

  task automatic test_reset();
    bus.mute = 0; bus.vol_up = 0; bus.vol_down = 0; bus.oct_up = 0; bus.oct_down = 0;
    bus.freq_in = {16'd0, 16'd440};
    rst = 1; step(3);
    vecs++; if (bus.vol !== 3'd1) begin errs++; $display("FAIL reset_vol got %0d exp 1", bus.vol); end
    vecs++; if (bus.oct !== 2'd1) begin errs++; $display("FAIL reset_oct got %0d exp 1", bus.oct); end
    vecs++; if (bus.div_ready !== 1'b0) begin errs++; $display("FAIL reset_rdy got %b exp 0", bus.div_ready); end
    vecs++; if (bus.audio_out !== '0) begin errs++; $display("FAIL reset_audio got %h exp 0", bus.audio_out); end
    m_vol = 1; m_oct = 1;
    rst = 0;
  endtask

  task automatic test_first_pass();
    int n = 0;
    while (bus.div_ready !== 1'b1 && n < 80) begin step(1); n++; end
    vecs++; if (bus.div_ready !== 1'b1) begin errs++; $display("FAIL first_pass_rdy got %b exp 1 after %0d", bus.div_ready, n); end
    vecs++; if (int'(dut.div_q[0]) != exp_div(440, 1)) begin errs++; $display("FAIL div440 got %0d exp %0d", dut.div_q[0], exp_div(440, 1)); end
    step(2);
    vecs++; if (smp(0) !== 16'hE000) begin errs++; $display("FAIL ch0_low got %h exp e000", smp(0)); end
    vecs++; if (smp(1) !== 16'h0000) begin errs++; $display("FAIL ch1_rest got %h exp 0", smp(1)); end
  endtask

  task automatic test_octave();
    repeat (3) pulse(0, 0, 1, 0);
    vecs++; if (int'(bus.oct) != 2) begin errs++; $display("FAIL oct_sat_hi got %0d exp 2", bus.oct); end
    step(80);
    vecs++; if (int'(dut.div_q[0]) != exp_div(440, 2)) begin errs++; $display("FAIL div_oct2 got %0d exp %0d", dut.div_q[0], exp_div(440, 2)); end
    repeat (4) pulse(0, 0, 0, 1);
    vecs++; if (int'(bus.oct) != 0) begin errs++; $display("FAIL oct_sat_lo got %0d exp 0", bus.oct); end
    step(80);
    vecs++; if (int'(dut.div_q[0]) != exp_div(440, 0)) begin errs++; $display("FAIL div_oct0 got %0d exp %0d", dut.div_q[0], exp_div(440, 0)); end
    set_oct(1);
  endtask

  task automatic test_volume();
    logic [SAMPLE_W-1:0] a, s;
    logic [31:0] r;
    int v;
    repeat (6) pulse(1, 0, 0, 0);
    vecs++; if (int'(bus.vol) != 5) begin errs++; $display("FAIL vol_sat_hi got %0d exp 5", bus.vol); end
    step(2);
    a = 16'(6 << 12); s = smp(0);
    vecs++; if (s !== a && s !== 16'(-a)) begin errs++; $display("FAIL amp_vol5 got %h exp +-%h", s, a); end
    v = m_vol;
    pulse(1, 1, 0, 0);
    vecs++; if (int'(bus.vol) != v) begin errs++; $display("FAIL vol_both got %0d exp %0d", bus.vol, v); end
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      pulse(r[0], r[1], r[2], r[3]);
      vecs++; if (int'(bus.vol) != m_vol) begin errs++; $display("FAIL rnd_vol[%0d] got %0d exp %0d", i, bus.vol, m_vol); end
      vecs++; if (int'(bus.oct) != m_oct) begin errs++; $display("FAIL rnd_oct[%0d] got %0d exp %0d", i, bus.oct, m_oct); end
    end
    step(2);
    a = 16'((m_vol + 1) << 12); s = smp(0);
    vecs++; if (exp_div(440, m_oct) != 0 && s !== a && s !== 16'(-a)) begin errs++; $display("FAIL amp_rnd got %h exp +-%h", s, a); end
    set_oct(1);
  endtask

  task automatic test_boundary();
    set_oct(0);
    bus.freq_in = {16'd0, 16'd1};
    step(100);
    vecs++; if (smp(0) !== 16'h0000) begin errs++; $display("FAIL feff0_silent got %h exp 0", smp(0)); end
    bus.freq_in = {16'd0, 16'd2};
    step(100);
    vecs++; if (int'(dut.div_q[0]) != exp_div(2, 0)) begin errs++; $display("FAIL div_sat got %0d exp %0d", dut.div_q[0], exp_div(2, 0)); end
    vecs++; if (smp(0) === 16'h0000) begin errs++; $display("FAIL feff1_active got %h exp nonzero", smp(0)); end
    vecs++; if (smp(1) !== 16'h0000) begin errs++; $display("FAIL ch1_rest2 got %h exp 0", smp(1)); end
  endtask

  task automatic test_tone_random();
    int f0, f1, o, t, sp, d;
    bit ok;
    for (int it = 0; it < 2; it++) begin
      f0 = $urandom_range(65000, 30000);
      f1 = $urandom_range(65000, 30000);
      o  = $urandom_range(2, 0);
      set_oct(o);
      bus.freq_in = {16'(f1), 16'(f0)};
      step(100);
      d = exp_div(f0, o);
      measure(0, 3 * (d + 2) + 10, t, sp, ok);
      vecs++; if (!ok || sp != d + 1) begin errs++; $display("FAIL tone0[%0d] f=%0d oct=%0d spacing %0d exp %0d", it, f0, o, sp, d + 1); end
      d = exp_div(f1, o);
      measure(1, 3 * (d + 2) + 10, t, sp, ok);
      vecs++; if (!ok || sp != d + 1) begin errs++; $display("FAIL tone1[%0d] f=%0d oct=%0d spacing %0d exp %0d", it, f1, o, sp, d + 1); end
    end
  endtask

  task automatic test_mute();
    int t0, t1, sp, d;
    bit ok;
    set_oct(1);
    bus.freq_in = {16'd0, 16'd20000};
    step(100);
    d = exp_div(20000, 1);
    measure(0, 3 * (d + 2), t0, sp, ok);
    t0 = t0 + sp;
    vecs++; if (!ok) begin errs++; $display("FAIL mute_pre no toggle found, exp spacing %0d", d + 1); end
    bus.mute = 1;
    step(1);
    vecs++; if (bus.audio_out !== '0) begin errs++; $display("FAIL mute_zero got %h exp 0", bus.audio_out); end
    step(999);
    vecs++; if (bus.audio_out !== '0) begin errs++; $display("FAIL mute_hold got %h exp 0", bus.audio_out); end
    bus.mute = 0;
    measure(0, 3 * (d + 2), t1, sp, ok);
    vecs++; if (!ok || sp != d + 1 || ((t1 - t0) % (d + 1)) != 0) begin
      errs++; $display("FAIL mute_phase offset %0d spacing %0d exp multiple/%0d", t1 - t0, sp, d + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bus.freq_in = {16'd20000, 16'd20000};
    while (!(dut.state_q == S_ITER && int'(dut.ch_q) == 1) && n < 200) begin step(1); n++; end
    vecs++; if (n >= 200) begin errs++; $display("FAIL reach_iter_ch1 got timeout exp ITER ch1"); end
    pulse(1, 0, 1, 0);
    rst = 1; step(1);
    m_vol = 1; m_oct = 1;
    vecs++; if (bus.vol !== 3'd1 || bus.oct !== 2'd1) begin errs++; $display("FAIL midrst_volo got %0d/%0d exp 1/1", bus.vol, bus.oct); end
    vecs++; if (bus.div_ready !== 1'b0) begin errs++; $display("FAIL midrst_rdy got %b exp 0", bus.div_ready); end
    vecs++; if (bus.audio_out !== '0) begin errs++; $display("FAIL midrst_audio got %h exp 0", bus.audio_out); end
    rst = 0;
    n = 0;
    while (dut.state_q != S_STORE && n < 100) begin step(1); n++; end
    vecs++; if (n >= 100 || int'(dut.ch_q) != 0) begin errs++; $display("FAIL first_store_ch got %0d exp 0 (wait %0d)", dut.ch_q, n); end
  endtask

  initial begin
    step(1);
    test_reset();
    test_first_pass();
    test_octave();
    test_volume();
    test_boundary();
    test_tone_random();
    test_mute();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
